// File: rtl/dpwm_capture.sv
// Gate-drive pair capture: recovers period, c1 high time and both deadtimes of a
// complementary c1/c2 pair, in hf_clock cycles, and flags timeout/order/overlap faults.
module dpwm_capture #(
    parameter int unsigned RESOLUTION  = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  hf_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  c1,
    input  logic                  c2,
    output logic [RESOLUTION-1:0] period,
    output logic [RESOLUTION-1:0] duty_cycle,
    output logic [RESOLUTION-1:0] deadtime2,
    output logic [RESOLUTION-1:0] deadtime1,
    output logic                  meas_valid,
    output logic                  timeout,
    output logic                  seq_error,
    output logic                  overlap_fault
);

    localparam int unsigned W  = RESOLUTION;
    localparam int unsigned NS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [W-1:0] CNT_NEAR = CNT_MAX - W'(1);

    typedef enum logic [2:0] {WAIT_SYNC, HIGH, DT2, LOW, DT1} state_t;

    state_t         state, state_n;
    logic [NS-1:0]  c1_sync, c2_sync;
    logic           c1_q, c1_qq, c2_q, c2_qq;
    logic           r1, f1, r2, f2, ovl, tmo_hit;
    logic [W-1:0]   pcnt, ts, t_d, t_f, d2;
    logic           set_td, zero_d2, set_d2, set_tf, done, zero_d1, err_c, tmo_c;

    // Synchronizer chain followed by a level/history pair; edges and overlap share one alignment
    always_ff @(posedge hf_clock) begin
        if (reset) begin
            c1_sync <= '0;
            c2_sync <= '0;
            c1_q    <= 1'b0;
            c1_qq   <= 1'b0;
            c2_q    <= 1'b0;
            c2_qq   <= 1'b0;
        end else begin
            c1_sync <= NS'({c1_sync, c1});
            c2_sync <= NS'({c2_sync, c2});
            c1_q    <= c1_sync[NS-1];
            c1_qq   <= c1_q;
            c2_q    <= c2_sync[NS-1];
            c2_qq   <= c2_q;
        end
    end

    assign r1      = c1_q & ~c1_qq;
    assign f1      = ~c1_q & c1_qq;
    assign r2      = c2_q & ~c2_qq;
    assign f2      = ~c2_q & c2_qq;
    assign ovl     = enable & c1_q & c2_q;
    assign ts      = pcnt + W'(1);
    assign tmo_hit = (state != WAIT_SYNC) && !r1 && (pcnt >= CNT_NEAR);

    always_ff @(posedge hf_clock) begin
        if (reset) state <= WAIT_SYNC;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!enable || ovl || tmo_hit) begin
            state_n = WAIT_SYNC;
        end else begin
            case (state)
                WAIT_SYNC: if (r1) state_n = HIGH;
                HIGH:      if (r1 | f2 | (r2 & ~f1)) state_n = WAIT_SYNC;
                           else if (f1)              state_n = r2 ? LOW : DT2;
                DT2:       if (r1 | f1 | f2)         state_n = WAIT_SYNC;
                           else if (r2)              state_n = LOW;
                LOW:       if (r2 | f1 | (r1 & ~f2)) state_n = WAIT_SYNC;
                           else if (f2)              state_n = r1 ? HIGH : DT1;
                DT1:       if (r2 | f1 | f2)         state_n = WAIT_SYNC;
                           else if (r1)              state_n = HIGH;
                default:                             state_n = WAIT_SYNC;
            endcase
        end
    end

    // Datapath controls; overlap and disable mask every event, timeout outranks edge errors
    always_comb begin
        set_td  = 1'b0;
        zero_d2 = 1'b0;
        set_d2  = 1'b0;
        set_tf  = 1'b0;
        done    = 1'b0;
        zero_d1 = 1'b0;
        err_c   = 1'b0;
        tmo_c   = 1'b0;
        if (enable && !ovl) begin
            if (tmo_hit) begin
                tmo_c = 1'b1;
            end else begin
                case (state)
                    HIGH: if (r1 | f2 | (r2 & ~f1)) err_c = 1'b1;
                          else if (f1) begin
                              set_td  = 1'b1;
                              zero_d2 = r2;
                          end
                    DT2:  if (r1 | f1 | f2) err_c = 1'b1;
                          else if (r2) set_d2 = 1'b1;
                    LOW:  if (r2 | f1 | (r1 & ~f2)) err_c = 1'b1;
                          else if (f2) begin
                              set_tf  = 1'b1;
                              done    = r1;
                              zero_d1 = r1;
                          end
                    DT1:  if (r2 | f1 | f2) err_c = 1'b1;
                          else if (r1) done = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge hf_clock) begin
        if (reset) begin
            pcnt          <= '0;
            t_d           <= '0;
            t_f           <= '0;
            d2            <= '0;
            period        <= '0;
            duty_cycle    <= '0;
            deadtime2     <= '0;
            deadtime1     <= '0;
            meas_valid    <= 1'b0;
            timeout       <= 1'b0;
            seq_error     <= 1'b0;
            overlap_fault <= 1'b0;
        end else begin
            if (r1)                   pcnt <= '0;
            else if (pcnt != CNT_MAX) pcnt <= pcnt + W'(1);
            if (set_td) begin
                t_d <= ts;
                if (zero_d2) d2 <= '0;
            end
            if (set_d2) d2  <= ts - t_d;
            if (set_tf) t_f <= ts;
            if (done) begin
                period     <= ts;
                duty_cycle <= t_d;
                deadtime2  <= d2;
                deadtime1  <= zero_d1 ? '0 : ts - t_f;
            end
            meas_valid    <= done;
            timeout       <= tmo_c;
            seq_error     <= err_c;
            overlap_fault <= overlap_fault | ovl;
        end
    end

endmodule

// File: tb/tb_dpwm_capture.sv
// Scoreboard bench for dpwm_capture: expected descriptors queued per driven period,
// compared when meas_valid fires; fault pulses counted and timed.
module tb_dpwm_capture;

    localparam int unsigned RES = 8;
    localparam int unsigned SS  = 2;

    typedef struct packed {
        logic [RES-1:0] p;
        logic [RES-1:0] d;
        logic [RES-1:0] t2;
        logic [RES-1:0] t1;
    } meas_t;

    logic           hf_clock = 1'b0;
    logic           reset, enable, c1, c2;
    logic [RES-1:0] period, duty_cycle, deadtime2, deadtime1;
    logic           meas_valid, timeout, seq_error, overlap_fault;

    meas_t exp_q[$];
    meas_t last_m = '0;
    int    n_tests = 0, n_fail = 0;
    int    cyc = 0;
    int    mv_cnt = 0, tmo_cnt = 0, seq_cnt = 0, tmo_cyc = 0;

    dpwm_capture #(.RESOLUTION(RES), .SYNC_STAGES(SS)) dut (
        .hf_clock(hf_clock), .reset(reset), .enable(enable), .c1(c1), .c2(c2),
        .period(period), .duty_cycle(duty_cycle), .deadtime2(deadtime2), .deadtime1(deadtime1),
        .meas_valid(meas_valid), .timeout(timeout), .seq_error(seq_error),
        .overlap_fault(overlap_fault)
    );

    always #5 hf_clock = ~hf_clock;
    always @(posedge hf_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor, sampled 1 ns after the active edge
    always @(posedge hf_clock) begin
        meas_t m;
        #1;
        if (meas_valid) begin
            mv_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_meas_valid", exp_q.size(), 1);
            end else begin
                m = exp_q.pop_front();
                check("period", period, m.p);
                check("duty_cycle", duty_cycle, m.d);
                check("deadtime2", deadtime2, m.t2);
                check("deadtime1", deadtime1, m.t1);
                last_m = m;
            end
        end
        if (timeout) begin
            tmo_cnt++;
            tmo_cyc = cyc;
        end
        if (seq_error) begin
            seq_cnt++;
            check("seq_hold_period", period, last_m.p);
            check("seq_hold_duty", duty_cycle, last_m.d);
        end
    end

    // One period of the pair; glitch/ovl inject a 1-cycle pulse, dis_at drops enable
    task automatic drive_period(input int hi, input int dt2, input int c2hi, input int dt1,
                                input bit exp, input int glitch, input int ovl,
                                input int dis_at, output int t0);
        int    p;
        meas_t m;
        p = hi + dt2 + c2hi + dt1;
        t0 = 0;
        if (exp) begin
            m.p  = RES'(p);
            m.d  = RES'(hi);
            m.t2 = RES'(dt2);
            m.t1 = RES'(dt1);
            exp_q.push_back(m);
        end
        for (int i = 0; i < p; i++) begin
            @(negedge hf_clock);
            if (i == 0) t0 = cyc;
            if (i == dis_at) enable = 1'b0;
            c1 = (i < hi) || (i == glitch);
            c2 = ((i >= hi + dt2) && (i < hi + dt2 + c2hi)) || (i == ovl);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s_mv, s_seq, s_tmo;
        reset = 1'b1; enable = 1'b0; c1 = 1'b0; c2 = 1'b0;
        repeat (3) @(negedge hf_clock);
        reset = 1'b0;
        @(negedge hf_clock);
        check("rst_period", period, 0);
        check("rst_duty", duty_cycle, 0);
        check("rst_dt2", deadtime2, 0);
        check("rst_dt1", deadtime1, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_overlap", overlap_fault, 0);

        enable = 1'b1;
        repeat (3) drive_period(40, 5, 48, 7, 1, -1, -1, -1, t0);
        repeat (3) drive_period(32, 0, 32, 0, 1, -1, -1, -1, t0);
        check("no_seq_yet", seq_cnt, 0);
        check("no_overlap_yet", overlap_fault, 0);

        // c1 re-rises inside deadtime2
        drive_period(40, 5, 48, 7, 0, 42, -1, -1, t0);
        check("seq_count", seq_cnt, 1);
        repeat (2) drive_period(40, 5, 48, 7, 1, -1, -1, -1, t0);

        // c2 pulses while c1 high
        drive_period(40, 5, 48, 7, 0, -1, 20, -1, t0);
        check("overlap_set", overlap_fault, 1);
        check("overlap_no_seq", seq_cnt, 1);
        repeat (2) drive_period(40, 5, 48, 7, 1, -1, -1, -1, t0);
        check("overlap_sticky", overlap_fault, 1);

        // c1 held high past counter saturation
        drive_period(300, 0, 0, 20, 0, -1, -1, -1, t0);
        check("timeout_count", tmo_cnt, 1);
        check("timeout_latency", tmo_cyc - t0, SS + 257);
        repeat (2) drive_period(40, 5, 48, 7, 1, -1, -1, -1, t0);

        drive_period(40, 5, 48, 7, 0, -1, -1, 20, t0);
        s_mv = mv_cnt; s_seq = seq_cnt; s_tmo = tmo_cnt;
        drive_period(40, 5, 48, 7, 0, 42, -1, -1, t0);
        drive_period(300, 0, 0, 20, 0, -1, -1, -1, t0);
        drive_period(40, 5, 48, 7, 0, -1, -1, -1, t0);
        check("dis_no_valid", mv_cnt, s_mv);
        check("dis_no_seq", seq_cnt, s_seq);
        check("dis_no_timeout", tmo_cnt, s_tmo);
        check("dis_hold_period", period, 100);
        check("dis_hold_overlap", overlap_fault, 1);

        @(negedge hf_clock);
        c1 = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge hf_clock);
        reset = 1'b0;
        c1 = 1'b0;
        @(negedge hf_clock);
        check("rst2_period", period, 0);
        check("rst2_duty", duty_cycle, 0);
        check("rst2_dt2", deadtime2, 0);
        check("rst2_dt1", deadtime1, 0);
        check("rst2_overlap", overlap_fault, 0);

        enable = 1'b1;
        s_mv = mv_cnt;
        drive_period(40, 5, 48, 7, 1, -1, -1, -1, t0);
        check("arm_only", mv_cnt, s_mv);
        @(negedge hf_clock);
        c1 = 1'b1;
        repeat (10) @(negedge hf_clock);
        check("post_reset_valid", mv_cnt, s_mv + 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
